axi_arbiter_bridge: RTL and testbench

- Parametrised successor to the core's single-master AXI glue.
- Arbitrates an instruction-fetch request port (IFU) and a load/store request port (LSU) onto one AXI4 master with configurable address/data width.
- Adds per-port IDs, a real write-response phase, concurrent AW/W issue, narrow-read lane extraction and error reporting.
- Sits between the core pipeline and the SoC crossbar; exactly one transaction is outstanding at a time.

---
 rtl/axi_bridge_pkg.sv | 26 ++
 rtl/axi_rdata_align.sv | 32 +++
 rtl/axi_arbiter_bridge.sv | 256 +++++++++++++++++++++++++
 tb/tb_axi_arbiter_bridge.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_bridge_pkg.sv
// Shared types and helpers for the IFU/LSU to AXI4 arbiter bridge.
package axi_bridge_pkg;

    // Bridge FSM states; exactly one AXI transaction is in flight outside S_IDLE.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam logic [1:0] BURST_INCR    = 2'b01;

    // Default data width and its strobe width; the top derives its own from DATA_W.
    localparam int DATA_W_DEFAULT = 32;
    localparam int STRB_W         = DATA_W_DEFAULT / 8;

    // Number of bytes covered by an AXI size encoding.
    function automatic logic [7:0] size_of_bytes(input logic [2:0] size);
        size_of_bytes = 8'd1 << size;
    endfunction

endpackage

// File: rtl/axi_rdata_align.sv
// Read-data lane extraction: right-justifies the addressed bytes, zero-fills
// above the access size, and picks the 32-bit instruction lane for fetches.
module axi_rdata_align
    import axi_bridge_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]            rdata,
    input  logic [$clog2(DATA_W/8)-1:0]  off,
    input  logic [2:0]                   size,
    output logic [DATA_W-1:0]            lsu_data,
    output logic [31:0]                  ifu_data
);

    logic [DATA_W-1:0] shifted;
    logic [7:0]        nbytes;

    // Shift the addressed byte down to lane 0, then keep only the bytes of the access.
    // Fetch addresses are word aligned, so the same shift leaves the instruction in [31:0].
    always_comb begin
        shifted  = rdata >> {off, 3'b000};
        nbytes   = size_of_bytes(size);
        lsu_data = '0;
        for (int i = 0; i < DATA_W / 8; i++) begin
            if (i < int'(nbytes)) begin
                lsu_data[8*i +: 8] = shifted[8*i +: 8];
            end
        end
        ifu_data = shifted[31:0];
    end

endmodule

// File: rtl/axi_arbiter_bridge.sv
// Arbitrates the fetch (IFU) and load/store (LSU) request ports onto one AXI4
// master with a single outstanding transaction. The LSU has fixed priority.
//
// Handshake rule on every AXI channel and on both request ports: a transfer
// happens on a rising clock edge where valid and ready are both high; a valid
// held by this block never drops and its payload never changes until that edge.
// Responses back to the core are one-cycle pulses with no back-pressure.
module axi_arbiter_bridge
    import axi_bridge_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32,
    parameter logic [3:0] IFU_ID = 4'd0,
    parameter logic [3:0] LSU_ID = 4'd1
) (
    input  logic                  clock,
    input  logic                  reset,
    // fetch port
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_rsp_valid,
    output logic [31:0]           ifu_rsp_data,
    output logic                  ifu_rsp_err,
    // load/store port
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic                  lsu_wen,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic [2:0]            lsu_size,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wstrb,
    output logic                  lsu_rsp_valid,
    output logic [DATA_W-1:0]     lsu_rsp_rdata,
    output logic                  lsu_rsp_err,
    // AXI4 write address
    output logic                  io_master_awvalid,
    input  logic                  io_master_awready,
    output logic [ADDR_W-1:0]     io_master_awaddr,
    output logic [3:0]            io_master_awid,
    output logic [7:0]            io_master_awlen,
    output logic [2:0]            io_master_awsize,
    output logic [1:0]            io_master_awburst,
    // AXI4 write data
    output logic                  io_master_wvalid,
    input  logic                  io_master_wready,
    output logic [DATA_W-1:0]     io_master_wdata,
    output logic [DATA_W/8-1:0]   io_master_wstrb,
    output logic                  io_master_wlast,
    // AXI4 write response
    input  logic                  io_master_bvalid,
    output logic                  io_master_bready,
    input  logic [3:0]            io_master_bid,
    input  logic [1:0]            io_master_bresp,
    // AXI4 read address
    output logic                  io_master_arvalid,
    input  logic                  io_master_arready,
    output logic [ADDR_W-1:0]     io_master_araddr,
    output logic [3:0]            io_master_arid,
    output logic [7:0]            io_master_arlen,
    output logic [2:0]            io_master_arsize,
    output logic [1:0]            io_master_arburst,
    // AXI4 read data
    input  logic                  io_master_rvalid,
    output logic                  io_master_rready,
    input  logic [3:0]            io_master_rid,
    input  logic [DATA_W-1:0]     io_master_rdata,
    input  logic [1:0]            io_master_rresp,
    input  logic                  io_master_rlast,
    // debug
    output state_t                dbg_state
);

    localparam int OFF_W = $clog2(DATA_W / 8);

    state_t                state_q, state_d;
    logic                  lsu_win_q, lsu_win_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [2:0]            size_q, size_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
    logic                  arvalid_q, arvalid_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  lsu_take;
    logic                  ifu_take;
    logic                  aw_fin;
    logic                  w_fin;
    logic [3:0]            exp_id;
    logic [DATA_W-1:0]     lsu_aligned;
    logic [31:0]           ifu_word;
    logic                  unused_rlast;

    // rlast is ignored: every burst is a single beat.
    assign unused_rlast = io_master_rlast;

    // Arbitration is only open in idle and never while reset is asserted.
    assign lsu_take = (state_q == S_IDLE) && reset && lsu_req_valid;
    assign ifu_take = (state_q == S_IDLE) && reset && !lsu_req_valid && ifu_req_valid;
    assign lsu_req_ready = lsu_take;
    assign ifu_req_ready = ifu_take;

    assign exp_id = lsu_win_q ? LSU_ID : IFU_ID;
    assign aw_fin = !awvalid_q || io_master_awready;
    assign w_fin  = !wvalid_q  || io_master_wready;

    axi_rdata_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .rdata    (io_master_rdata),
        .off      (addr_q[OFF_W-1:0]),
        .size     (size_q),
        .lsu_data (lsu_aligned),
        .ifu_data (ifu_word)
    );

    // Next-state and next-payload logic for the single-transaction FSM.
    always_comb begin
        state_d    = state_q;
        lsu_win_d  = lsu_win_q;
        addr_d     = addr_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        arvalid_d  = arvalid_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (lsu_take) begin
                    lsu_win_d = 1'b1;
                    addr_d    = lsu_addr;
                    size_d    = lsu_size;
                    wdata_d   = lsu_wdata;
                    wstrb_d   = lsu_wstrb;
                    if (lsu_wen) begin
                        state_d   = S_WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end else if (ifu_take) begin
                    lsu_win_d = 1'b0;
                    addr_d    = ifu_addr;
                    size_d    = 3'd2;
                    wdata_d   = '0;
                    wstrb_d   = '0;
                    state_d   = S_RD_ADDR;
                    arvalid_d = 1'b1;
                end
            end
            S_RD_ADDR: begin
                if (io_master_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (io_master_rvalid) begin
                    if (lsu_win_q) begin
                        rsp_data_d = lsu_aligned;
                    end else begin
                        rsp_data_d       = '0;
                        rsp_data_d[31:0] = ifu_word;
                    end
                    rsp_err_d = (io_master_rresp != AXI_RESP_OKAY) || (io_master_rid != exp_id);
                    state_d   = S_RESP;
                end
            end
            S_WR_REQ: begin
                if (io_master_awready) awvalid_d = 1'b0;
                if (io_master_wready)  wvalid_d  = 1'b0;
                if (aw_fin && w_fin)   state_d   = S_WR_RESP;
            end
            S_WR_RESP: begin
                if (io_master_bvalid) begin
                    rsp_data_d = '0;
                    rsp_err_d  = (io_master_bresp != AXI_RESP_OKAY) || (io_master_bid != exp_id);
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and payload registers; reset abandons any transaction in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            lsu_win_q  <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            arvalid_q  <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lsu_win_q  <= lsu_win_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            arvalid_q  <= arvalid_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign io_master_arvalid = arvalid_q;
    assign io_master_araddr  = addr_q;
    assign io_master_arid    = exp_id;
    assign io_master_arlen   = 8'd0;
    assign io_master_arsize  = size_q;
    assign io_master_arburst = BURST_INCR;
    assign io_master_rready  = (state_q == S_RD_DATA);

    assign io_master_awvalid = awvalid_q;
    assign io_master_awaddr  = addr_q;
    assign io_master_awid    = exp_id;
    assign io_master_awlen   = 8'd0;
    assign io_master_awsize  = size_q;
    assign io_master_awburst = BURST_INCR;
    assign io_master_wvalid  = wvalid_q;
    assign io_master_wdata   = wdata_q;
    assign io_master_wstrb   = wstrb_q;
    assign io_master_wlast   = wvalid_q;
    assign io_master_bready  = (state_q == S_WR_RESP);

    assign ifu_rsp_valid = (state_q == S_RESP) && !lsu_win_q;
    assign lsu_rsp_valid = (state_q == S_RESP) && lsu_win_q;
    assign ifu_rsp_data  = rsp_data_q[31:0];
    assign lsu_rsp_rdata = rsp_data_q;
    assign ifu_rsp_err   = rsp_err_q;
    assign lsu_rsp_err   = rsp_err_q;

    assign dbg_state = state_q;

endmodule

// File: tb/tb_axi_arbiter_bridge.sv
// Bench for axi_arbiter_bridge at DATA_W=64: table vectors with hand-derived
// expectations, hand-written arbitration/reset sequences, and random traffic
// checked against a byte-arithmetic reference model.
module tb_axi_arbiter_bridge;
  import axi_bridge_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;

  typedef struct {
    bit          is_lsu;
    bit          wen;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] rdata;
    logic [1:0]  resp;
    logic [3:0]  rsp_id;
    int          a_dly;
    int          w_dly;
    int          r_dly;
    logic [63:0] exp_data;
    bit          exp_err;
  } vec_t;

  // ---------------- clock / reset / signals ----------------
  logic clock;
  logic reset;
  logic ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic [AW-1:0] ifu_addr;
  logic [31:0] ifu_rsp_data;
  logic lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
  logic [AW-1:0] lsu_addr;
  logic [2:0] lsu_size;
  logic [DW-1:0] lsu_wdata, lsu_rsp_rdata;
  logic [DW/8-1:0] lsu_wstrb;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic arvalid, arready, rvalid, rready, rlast;
  logic [AW-1:0] awaddr, araddr;
  logic [3:0] awid, arid, bid, rid;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  state_t dbg_state;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  axi_arbiter_bridge #(
    .ADDR_W(AW), .DATA_W(DW), .IFU_ID(4'd0), .LSU_ID(4'd1)
  ) dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr), .lsu_size(lsu_size), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata), .lsu_rsp_err(lsu_rsp_err),
    .io_master_awvalid(awvalid), .io_master_awready(awready), .io_master_awaddr(awaddr),
    .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize), .io_master_awburst(awburst),
    .io_master_wvalid(wvalid), .io_master_wready(wready), .io_master_wdata(wdata),
    .io_master_wstrb(wstrb), .io_master_wlast(wlast),
    .io_master_bvalid(bvalid), .io_master_bready(bready), .io_master_bid(bid), .io_master_bresp(bresp),
    .io_master_arvalid(arvalid), .io_master_arready(arready), .io_master_araddr(araddr),
    .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize), .io_master_arburst(arburst),
    .io_master_rvalid(rvalid), .io_master_rready(rready), .io_master_rid(rid),
    .io_master_rdata(rdata), .io_master_rresp(rresp), .io_master_rlast(rlast),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [64:0] exp_q[$];   // {err, data}

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: response derived from byte arithmetic on the AXI beat.
  task automatic model(inout vec_t v);
    logic [127:0] wide;
    logic [127:0] mask;
    int off;
    int n;
    logic [3:0] eid;
    eid = v.is_lsu ? 4'd1 : 4'd0;
    v.exp_err = (v.resp != 2'b00) || (v.rsp_id != eid);
    off  = int'(v.addr[2:0]);
    n    = 1 << v.size;
    if (v.is_lsu && v.wen) begin
      v.exp_data = 64'd0;
    end else if (!v.is_lsu) begin
      v.exp_data = v.addr[2] ? {32'd0, v.rdata[63:32]} : {32'd0, v.rdata[31:0]};
    end else begin
      wide = {64'd0, v.rdata} >> (8 * off);
      mask = (128'd1 << (8 * n)) - 128'd1;
      v.exp_data = 64'(wide & mask);
    end
  endtask

  function automatic vec_t mk(bit lsu, bit wen, logic [31:0] addr, logic [2:0] size,
                              logic [63:0] wd, logic [7:0] ws, logic [63:0] rd, logic [1:0] resp,
                              logic [3:0] id, int ad, int wdl, int rdl, logic [63:0] ed, bit ee);
    vec_t v;
    v.is_lsu = lsu; v.wen = wen; v.addr = addr; v.size = size; v.wdata = wd; v.wstrb = ws;
    v.rdata = rd; v.resp = resp; v.rsp_id = id; v.a_dly = ad; v.w_dly = wdl; v.r_dly = rdl;
    v.exp_data = ed; v.exp_err = ee;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input vec_t v);
    @(negedge clock);
    if (v.is_lsu) begin
      lsu_req_valid = 1'b1; lsu_wen = v.wen; lsu_addr = v.addr; lsu_size = v.size;
      lsu_wdata = v.wdata; lsu_wstrb = v.wstrb;
    end else begin
      ifu_req_valid = 1'b1; ifu_addr = v.addr;
    end
    #1;
    check("req_ready", v.is_lsu ? lsu_req_ready : ifu_req_ready, 1'b1);
    @(posedge clock);
    #1;
    // Scramble the request payload to prove the bridge latched it.
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    lsu_addr = $urandom; ifu_addr = $urandom; lsu_wdata = {$urandom, $urandom};
    lsu_wstrb = 8'($urandom); lsu_size = 3'($urandom_range(0, 7)); lsu_wen = 1'($urandom);
  endtask

  // Slave side of one transaction, starting the cycle after the accept.
  task automatic serve(input vec_t v);
    logic [3:0] eid;
    logic [64:0] e;
    bit ok, hs, aw_done, w_done, aw_hs, w_hs;
    eid = v.is_lsu ? 4'd1 : 4'd0;
    ok = 1'b0;
    if (!(v.is_lsu && v.wen)) begin
      for (int c = 0; c < 40; c++) begin
        @(negedge clock);
        arready = (c >= v.a_dly);
        #1;
        if (c == 0) begin
          check("araddr", araddr, v.addr);
          check("arsize", arsize, v.is_lsu ? v.size : 3'd2);
          check("arid", arid, eid);
          check("arlen_burst", {arlen, arburst}, {8'd0, 2'b01});
        end
        check("arvalid_held", arvalid, 1'b1);
        check("rready_low_in_ar", rready, 1'b0);
        check("ready_busy", {ifu_req_ready, lsu_req_ready}, 2'b00);
        hs = arready && arvalid;
        @(posedge clock);
        if (hs) begin ok = 1'b1; break; end
      end
      check("ar_handshake_seen", ok, 1'b1);
      #1 arready = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clock);
        rvalid = (c >= v.r_dly); rdata = v.rdata; rresp = v.resp; rid = v.rsp_id; rlast = 1'b1;
        #1;
        check("rready_in_rdata", rready, 1'b1);
        check("arvalid_dropped", arvalid, 1'b0);
        check("no_early_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
        hs = rvalid && rready;
        @(posedge clock);
        if (hs) begin ok = 1'b1; break; end
      end
      check("r_handshake_seen", ok, 1'b1);
      #1 rvalid = 1'b0; rdata = {$urandom, $urandom};
    end else begin
      aw_done = 1'b0; w_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clock);
        awready = (c >= v.a_dly); wready = (c >= v.w_dly);
        #1;
        if (c == 0) begin
          check("awaddr", awaddr, v.addr);
          check("awsize_id", {awsize, awid}, {v.size, eid});
          check("awlen_burst", {awlen, awburst}, {8'd0, 2'b01});
          check("wdata", wdata, v.wdata);
          check("wstrb", wstrb, v.wstrb);
        end
        check("awvalid", awvalid, !aw_done);
        check("wvalid", wvalid, !w_done);
        check("wlast", wlast, !w_done);
        check("bready_low_in_wr", bready, 1'b0);
        check("ready_busy", {ifu_req_ready, lsu_req_ready}, 2'b00);
        aw_hs = awready && awvalid;
        w_hs  = wready && wvalid;
        @(posedge clock);
        aw_done = aw_done | aw_hs;
        w_done  = w_done | w_hs;
        if (aw_done && w_done) begin ok = 1'b1; break; end
      end
      check("aw_w_done", ok, 1'b1);
      #1 awready = 1'b0; wready = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clock);
        bvalid = (c >= v.r_dly); bresp = v.resp; bid = v.rsp_id;
        #1;
        check("bready_in_wresp", bready, 1'b1);
        check("no_early_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
        hs = bvalid && bready;
        @(posedge clock);
        if (hs) begin ok = 1'b1; break; end
      end
      check("b_handshake_seen", ok, 1'b1);
      #1 bvalid = 1'b0;
    end
    e = exp_q.pop_front();
    @(negedge clock);
    #1;
    check("rsp_valid_ifu", ifu_rsp_valid, !v.is_lsu);
    check("rsp_valid_lsu", lsu_rsp_valid, v.is_lsu);
    if (v.is_lsu) begin
      check("lsu_rdata", lsu_rsp_rdata, e[63:0]);
      check("lsu_err", lsu_rsp_err, e[64]);
    end else begin
      check("ifu_data", ifu_rsp_data, e[31:0]);
      check("ifu_err", ifu_rsp_err, e[64]);
    end
    check("axi_quiet_in_resp", {rready, bready, arvalid, awvalid, wvalid}, 5'd0);
    check("ready_busy_resp", {ifu_req_ready, lsu_req_ready}, 2'b00);
    @(posedge clock);
    @(negedge clock);
    #1;
    check("rsp_pulse_end", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
  endtask

  task automatic run_vec(input vec_t v);
    exp_q.push_back({v.exp_err, v.exp_data});
    issue(v);
    serve(v);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valids"}, {arvalid, awvalid, wvalid, rready, bready, ifu_req_ready,
                             lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid}, 9'd0);
    check({tag, "_rsp"}, {ifu_rsp_data, lsu_rsp_rdata, ifu_rsp_err, lsu_rsp_err}, 98'd0);
    check({tag, "_payload"}, {araddr, awaddr, arsize, awsize, wstrb}, 78'd0);
    check({tag, "_wdata"}, wdata, 64'd0);
    check({tag, "_state"}, dbg_state, 3'd0);
  endtask

  // ---------------- stimulus ----------------
  vec_t tbl[13];
  vec_t r, v_l, v_i;

  initial begin
    reset = 1'b0;
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_size = '0; lsu_wdata = '0; lsu_wstrb = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
    arready = 1'b0; rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;

    // Table: {lsu, wen, addr, size, wdata, wstrb, rdata, resp, id, a_dly, w_dly, r/b_dly, exp_data, exp_err}
    tbl[0]  = mk(0, 0, 32'h8000_0004, 3'd2, 64'd0, 8'h00, 64'h0000_0013_DEAD_BEEF, 2'd0, 4'd0, 0, 0, 0, 64'h13, 0);
    tbl[1]  = mk(0, 0, 32'h8000_0008, 3'd2, 64'd0, 8'h00, 64'hCAFE_F00D_0000_0093, 2'd0, 4'd0, 2, 0, 1, 64'h93, 0);
    tbl[2]  = mk(1, 0, 32'h0000_1003, 3'd0, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 2'd0, 4'd1, 0, 0, 0, 64'h55, 0);
    tbl[3]  = mk(1, 0, 32'h0000_1006, 3'd1, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 2'd0, 4'd1, 1, 0, 0, 64'h1122, 0);
    tbl[4]  = mk(1, 0, 32'h0000_1004, 3'd2, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 2'd0, 4'd1, 0, 0, 2, 64'h1122_3344, 0);
    tbl[5]  = mk(1, 0, 32'h0000_1000, 3'd3, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 2'd0, 4'd1, 0, 0, 3, 64'h1122_3344_5566_7788, 0);
    tbl[6]  = mk(1, 0, 32'h0000_2000, 3'd2, 64'd0, 8'h00, 64'h9999_9999_AABB_CCDD, 2'd2, 4'd1, 0, 0, 0, 64'hAABB_CCDD, 1);
    tbl[7]  = mk(1, 0, 32'h0000_2001, 3'd0, 64'd0, 8'h00, 64'h9999_9999_AABB_CCDD, 2'd0, 4'd5, 0, 0, 0, 64'hCC, 1);
    tbl[8]  = mk(1, 1, 32'h0000_3000, 3'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'd0, 2'd0, 4'd1, 3, 0, 0, 64'd0, 0);
    tbl[9]  = mk(1, 1, 32'h0000_3004, 3'd2, 64'hA5A5_0000_0000_0000, 8'hF0, 64'd0, 2'd3, 4'd1, 0, 2, 1, 64'd0, 1);
    tbl[10] = mk(1, 1, 32'h0000_3008, 3'd0, 64'h0000_0000_0000_007E, 8'h01, 64'd0, 2'd0, 4'd0, 0, 0, 2, 64'd0, 1);
    tbl[11] = mk(0, 0, 32'h8000_000C, 3'd2, 64'd0, 8'h00, 64'h0000_0073_0000_006F, 2'd0, 4'd1, 0, 0, 0, 64'h73, 1);
    tbl[12] = mk(1, 0, 32'h0000_1005, 3'd1, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 2'd0, 4'd1, 0, 0, 0, 64'h2233, 0);

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 13; i++) run_vec(tbl[i]);

    // Simultaneous requests: LSU first, IFU waits for idle
    v_l = mk(1, 0, 32'h0000_4002, 3'd1, 64'd0, 8'h00, 64'h0000_0000_BEEF_0000, 2'd0, 4'd1, 1, 0, 1, 64'hBEEF, 0);
    v_i = mk(0, 0, 32'h8000_1000, 3'd2, 64'd0, 8'h00, 64'h1234_5678_0000_0017, 2'd0, 4'd0, 0, 0, 0, 64'h17, 0);
    exp_q.push_back({v_l.exp_err, v_l.exp_data});
    exp_q.push_back({v_i.exp_err, v_i.exp_data});
    @(negedge clock);
    lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = v_l.addr; lsu_size = v_l.size;
    ifu_req_valid = 1'b1; ifu_addr = v_i.addr;
    #1;
    check("arb_lsu_ready", lsu_req_ready, 1'b1);
    check("arb_ifu_blocked", ifu_req_ready, 1'b0);
    @(posedge clock);
    #1 lsu_req_valid = 1'b0;
    serve(v_l);
    check("arb_ifu_ready_after", ifu_req_ready, 1'b1);
    @(posedge clock);
    #1 ifu_req_valid = 1'b0;
    serve(v_i);

    // Reset while waiting for read data: no pulse, everything cleared
    v_l = mk(1, 0, 32'h0000_5000, 3'd3, 64'd0, 8'h00, 64'd0, 2'd0, 4'd1, 0, 0, 0, 64'd0, 0);
    issue(v_l);
    @(negedge clock);
    arready = 1'b1;
    #1;
    check("mid_rst_arvalid", arvalid, 1'b1);
    @(posedge clock);
    #1 arready = 1'b0;
    @(negedge clock);
    #1;
    check("mid_rst_in_rdata", rready, 1'b1);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    rvalid = 1'b1; rdata = 64'hFFFF_FFFF_FFFF_FFFF; rid = 4'd1; rresp = 2'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      #1;
      check("mid_rst_no_pulse", {ifu_rsp_valid, lsu_rsp_valid, rready}, 3'd0);
    end
    rvalid = 1'b0;
    reset = 1'b1;
    run_vec(tbl[2]);
    run_vec(tbl[8]);

    // Random traffic against the reference model
    for (int k = 0; k < 40; k++) begin
      r.is_lsu = 1'($urandom_range(0, 1));
      r.wen    = r.is_lsu ? 1'($urandom_range(0, 1)) : 1'b0;
      r.size   = r.is_lsu ? 3'($urandom_range(0, 3)) : 3'd2;
      r.addr   = $urandom;
      if (!r.is_lsu) r.addr[1:0] = 2'b00;
      r.wdata  = {$urandom, $urandom};
      r.wstrb  = 8'($urandom);
      r.rdata  = {$urandom, $urandom};
      r.resp   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      r.rsp_id = ($urandom_range(0, 5) == 0) ? 4'($urandom) : (r.is_lsu ? 4'd1 : 4'd0);
      r.a_dly  = $urandom_range(0, 3);
      r.w_dly  = $urandom_range(0, 3);
      r.r_dly  = $urandom_range(0, 3);
      model(r);
      run_vec(r);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
